// File: rtl/iter_alu_if.sv
// Request/response bundle between a requester and the iterative ALU.
interface iter_alu_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      op;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             busy;

    modport master (
        output in_valid, op, in1, in2, out_ready,
        input  in_ready, out_valid, out, busy
    );

    modport slave (
        input  in_valid, op, in1, in2, out_ready,
        output in_ready, out_valid, out, busy
    );
endinterface

// File: rtl/iter_alu.sv
// Multi-cycle ALU: single-cycle logic ops, bit-serial shifts,
// shift-add multiply and restoring divide behind a valid/ready handshake.
module iter_alu #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      flush_i,
    iter_alu_if.slave bus
);
    localparam int CW = SHW + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [3:0] K_SLL  = 4'd5;
    localparam logic [3:0] K_SRL  = 4'd6;
    localparam logic [3:0] K_MUL  = 4'd10;
    localparam logic [3:0] K_DIVU = 4'd12;
    localparam logic [3:0] K_DIV  = 4'd14;

    logic [1:0]       state_q, state_d;
    logic [3:0]       kind_q, kind_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;

    logic [15:0]      oh;
    logic [3:0]       kind;
    logic [SHW-1:0]   shamt;
    logic             sdiv, neg1, neg2, last;
    logic [WIDTH-1:0] m1, m2;

    function automatic logic [WIDTH-1:0] shift1(
        input logic [WIDTH-1:0] v,
        input logic [3:0]       k
    );
        if (k == K_SLL) return v << 1;
        if (k == K_SRL) return v >> 1;
        return {v[WIDTH-1], v[WIDTH-1:1]};
    endfunction

    function automatic logic [2*WIDTH-1:0] mul_step(
        input logic [WIDTH-1:0] hi,
        input logic [WIDTH-1:0] lo,
        input logic [WIDTH-1:0] m
    );
        logic [WIDTH:0] sum;
        sum = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
        return {sum, lo[WIDTH-1:1]};
    endfunction

    // Remainder stays below the divisor, so the trial value fits WIDTH+1 bits.
    function automatic logic [2*WIDTH-1:0] div_step(
        input logic [WIDTH-1:0] r,
        input logic [WIDTH-1:0] q,
        input logic [WIDTH-1:0] d
    );
        logic [WIDTH:0] t;
        logic [WIDTH:0] diff;
        t    = {r, q[WIDTH-1]};
        diff = t - {1'b0, d};
        if (!diff[WIDTH]) return {diff[WIDTH-1:0], q[WIDTH-2:0], 1'b1};
        return {t[WIDTH-1:0], q[WIDTH-2:0], 1'b0};
    endfunction

    always_comb begin
        oh   = bus.op & (~bus.op + 16'd1);
        kind = '0;
        for (int i = 15; i >= 0; i--)
            if (bus.op[i]) kind = 4'(i);
    end

    assign shamt = bus.in2[SHW-1:0];
    assign sdiv  = kind >= K_DIV;
    assign neg1  = sdiv & bus.in1[WIDTH-1];
    assign neg2  = sdiv & bus.in2[WIDTH-1];
    assign m1    = neg1 ? -bus.in1 : bus.in1;
    assign m2    = neg2 ? -bus.in2 : bus.in2;
    assign last  = cnt_q == CW'(1);

    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        a_d     = a_q;
        res_d   = res_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        unique case (state_q)
            IDLE: if (bus.in_valid) begin
                state_d = DONE;
                kind_d  = kind;
                unique case (1'b1)
                    oh[0]: res_d = bus.in1 + bus.in2;
                    oh[1]: res_d = bus.in1 - bus.in2;
                    oh[2]: res_d = bus.in1 & bus.in2;
                    oh[3]: res_d = bus.in1 | bus.in2;
                    oh[4]: res_d = bus.in1 ^ bus.in2;
                    oh[5], oh[6], oh[7]: begin
                        if (shamt == '0) begin
                            res_d = bus.in1;
                        end else if (shamt == SHW'(1)) begin
                            res_d = shift1(bus.in1, kind);
                        end else begin
                            state_d = BUSY;
                            hi_d    = shift1(bus.in1, kind);
                            cnt_d   = {1'b0, shamt} - 1'b1;
                        end
                    end
                    oh[8]: res_d = WIDTH'($signed(bus.in1) < $signed(bus.in2));
                    oh[9]: res_d = WIDTH'(bus.in1 < bus.in2);
                    oh[10], oh[11]: begin
                        state_d      = BUSY;
                        {hi_d, lo_d} = mul_step('0, bus.in2, bus.in1);
                        a_d          = bus.in1;
                        cnt_d        = CW'(WIDTH - 1);
                    end
                    oh[12], oh[13], oh[14], oh[15]: begin
                        state_d      = BUSY;
                        {hi_d, lo_d} = div_step('0, m1, m2);
                        a_d          = m2;
                        qneg_d       = (neg1 ^ neg2) && (bus.in2 != '0);
                        rneg_d       = neg1;
                        cnt_d        = CW'(WIDTH);
                    end
                    default: res_d = '0;
                endcase
            end
            BUSY: begin
                cnt_d = cnt_q - 1'b1;
                if (kind_q < K_MUL) begin
                    hi_d = shift1(hi_q, kind_q);
                    if (last) res_d = hi_d;
                end else if (kind_q < K_DIVU) begin
                    {hi_d, lo_d} = mul_step(hi_q, lo_q, a_q);
                    if (last) res_d = (kind_q == K_MUL) ? lo_d : hi_d;
                end else if (!last) begin
                    {hi_d, lo_d} = div_step(hi_q, lo_q, a_q);
                end else if (kind_q[0]) begin
                    res_d = rneg_q ? -hi_q : hi_q;
                end else begin
                    res_d = qneg_q ? -lo_q : lo_q;
                end
                if (last) state_d = DONE;
            end
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush_i) state_d = IDLE;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            kind_q  <= '0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            a_q     <= '0;
            res_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            a_q     <= a_d;
            res_q   <= res_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
        end
    end

    assign bus.in_ready  = state_q == IDLE;
    assign bus.out_valid = state_q == DONE;
    assign bus.busy      = state_q == BUSY;
    assign bus.out       = res_q;
endmodule

// File: tb/tb_iter_alu.sv
// Directed bench for iter_alu: results, latencies, backpressure,
// flush and asynchronous reset behaviour at WIDTH=32.
module tb_iter_alu;
    localparam logic [15:0] ADD   = 16'h0001;
    localparam logic [15:0] SUB   = 16'h0002;
    localparam logic [15:0] XOR_  = 16'h0010;
    localparam logic [15:0] SLL   = 16'h0020;
    localparam logic [15:0] SRL   = 16'h0040;
    localparam logic [15:0] SRA   = 16'h0080;
    localparam logic [15:0] SLT   = 16'h0100;
    localparam logic [15:0] SLTU  = 16'h0200;
    localparam logic [15:0] MUL   = 16'h0400;
    localparam logic [15:0] MULHU = 16'h0800;
    localparam logic [15:0] DIVU  = 16'h1000;
    localparam logic [15:0] REMU  = 16'h2000;
    localparam logic [15:0] DIV   = 16'h4000;
    localparam logic [15:0] REM   = 16'h8000;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic seen;

    iter_alu_if #(.WIDTH(32)) bus ();

    iter_alu #(.WIDTH(32)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (flush),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [15:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat);
        int n;
        bus.op        = op;
        bus.in1       = a;
        bus.in2       = b;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in1      = ~a;
        bus.in2      = ~b;
        bus.op       = ADD;
        n = 1;
        while (!bus.out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "/lat"}, 64'(n), 64'(lat));
        chk(tag, bus.out, exp);
        @(posedge clk);
        #1;
        chk({tag, "/idle"}, bus.in_ready, 1);
    endtask

    task automatic start_divu();
        bus.op       = DIVU;
        bus.in1      = 32'd100;
        bus.in2      = 32'd7;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("divu/busy", bus.busy, 1);
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic no_result(input string tag);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen = 1'b1;
        end
        chk({tag, "/noresult"}, seen, 0);
        chk({tag, "/ready"}, bus.in_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1);
    end

    initial begin
        rst           = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.op        = '0;
        bus.in1       = '0;
        bus.in2       = '0;
        bus.out_ready = 1'b1;
        #2;
        chk("rst/in_ready", bus.in_ready, 1);
        chk("rst/out_valid", bus.out_valid, 0);
        chk("rst/busy", bus.busy, 0);
        chk("rst/out", bus.out, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_op("add_wrap", ADD, 32'hFFFF_FFFF, 32'h1, 32'h0, 1);
        run_op("sub", SUB, 32'd3, 32'd5, 32'hFFFF_FFFE, 1);
        run_op("xor", XOR_, 32'hF0F0, 32'hFF00, 32'h0FF0, 1);
        run_op("sltu", SLTU, 32'h1, 32'hFFFF_FFFF, 32'h1, 1);
        run_op("slt", SLT, 32'h1, 32'hFFFF_FFFF, 32'h0, 1);
        run_op("sra31", SRA, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 31);
        run_op("sll0", SLL, 32'h1, 32'd0, 32'h1, 1);
        run_op("sra1", SRA, 32'h8000_0000, 32'd1, 32'hC000_0000, 1);
        run_op("srl4", SRL, 32'h8000_0000, 32'd4, 32'h0800_0000, 4);
        run_op("sll_mask", SLL, 32'h3, 32'h25, 32'h60, 5);
        run_op("mul_ff", MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 32);
        run_op("mulhu_ff", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'hFFFF_FFFE, 32);
        run_op("mul_7x6", MUL, 32'd7, 32'd6, 32'd42, 32);
        run_op("mulhu_2p33", MULHU, 32'h8000_0000, 32'd4, 32'd2, 32);
        run_op("div_m7_2", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        run_op("rem_m7_2", REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        run_op("div_7_m2", DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
        run_op("rem_7_m2", REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);
        run_op("divu_5_0", DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 33);
        run_op("remu_5_0", REMU, 32'd5, 32'd0, 32'd5, 33);
        run_op("div_m5_0", DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 33);
        run_op("rem_m5_0", REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 33);
        run_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF,
               32'h8000_0000, 33);
        run_op("rem_ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 33);
        run_op("divu_100_7", DIVU, 32'd100, 32'd7, 32'd14, 33);
        run_op("remu_100_7", REMU, 32'd100, 32'd7, 32'd2, 33);
        run_op("op_add_sub", 16'h0003, 32'd5, 32'd3, 32'd8, 1);
        run_op("op_sub_mul", 16'h0402, 32'd5, 32'd3, 32'd2, 1);
        run_op("op_none", 16'h0000, 32'd5, 32'd3, 32'd0, 1);

        bus.out_ready = 1'b0;
        bus.op        = ADD;
        bus.in1       = 32'd2;
        bus.in2       = 32'd3;
        bus.in_valid  = 1'b1;
        @(posedge clk);
        #1;
        chk("bp/valid", bus.out_valid, 1);
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("bp/out", bus.out, 32'd5);
            chk("bp/in_ready", bus.in_ready, 0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp/release_valid", bus.out_valid, 0);
        chk("bp/release_ready", bus.in_ready, 1);

        flush        = 1'b1;
        bus.op       = ADD;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_idle/ready", bus.in_ready, 1);
        chk("flush_idle/valid", bus.out_valid, 0);

        start_divu();
        rst = 1'b1;
        #1;
        chk("rst_mid/in_ready", bus.in_ready, 1);
        chk("rst_mid/out_valid", bus.out_valid, 0);
        chk("rst_mid/busy", bus.busy, 0);
        chk("rst_mid/out", bus.out, 0);
        @(negedge clk);
        rst = 1'b0;
        no_result("rst_mid");
        run_op("rst_add", ADD, 32'd2, 32'd3, 32'd5, 1);

        start_divu();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_mid/busy", bus.busy, 0);
        no_result("flush_mid");
        run_op("flush_add", ADD, 32'd2, 32'd3, 32'd5, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/iter_alu.md
ITER_ALU -- requirements
Module: iter_alu

Interface
REQ-001 Parameter WIDTH, 32, operand/result width in bits; legal values 8, 16, 32, 64.
REQ-002 Parameter SHW, log2(WIDTH), shift-amount width; derived, not overridden.
REQ-003 clock  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 flush  input  1  synchronous abort of the operation in flight.
REQ-006 in_valid  input  1  operation request.
REQ-007 in_ready  output  1  block can accept a request.
REQ-008 op  input  16  one-hot opcode, LSB first: ADD SUB AND OR XOR SLL SRL SRA SLT SLTU MUL MULHU DIVU REMU DIV REM.
REQ-009 in1  input  WIDTH  first operand (dividend, shifted value).
REQ-010 in2  input  WIDTH  second operand (divisor, shift amount in [SHW-1:0]).
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  consumer takes result.
REQ-013 out  output  WIDTH  result.
REQ-014 busy  output  1  high in BUSY state.

Function
REQ-015 States IDLE, BUSY, DONE; in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-016 Accept SHALL occur on an edge with in_valid && in_ready; op, in1, in2 SHALL be captured then and later input changes ignored.
REQ-017 If op has several bits set, the lowest set bit SHALL select the operation; op==0 SHALL yield result 0 with single-cycle latency.
REQ-018 Latency L = edges from accept to first edge after which out_valid=1: ADD..XOR, SLT, SLTU, op==0: L=1 (IDLE->DONE directly).
REQ-019 SLL/SRL/SRA: one bit per cycle, L=max(1, in2[SHW-1:0]); shamt 0 returns in1 unchanged.
REQ-020 MUL (low WIDTH bits) and MULHU (high WIDTH bits, unsigned): shift-add, L=WIDTH.
REQ-021 DIVU/REMU/DIV/REM: restoring division on magnitudes plus one sign-fix cycle, L=WIDTH+1 for every operand value.
REQ-022 Divide by zero: DIVU/DIV result all ones, REMU/REM result = in1; DIV of most-negative by -1 = most-negative, REM = 0.
REQ-023 DIV quotient SHALL truncate toward zero; REM sign SHALL equal dividend sign.
REQ-024 ADD/SUB SHALL wrap modulo 2^WIDTH; SLT signed, SLTU unsigned, result 1 or 0.
REQ-025 SRA SHALL replicate in1 MSB; SRL SHALL insert zeros.
REQ-026 In DONE, out SHALL stay stable until the edge with out_ready=1, after which state SHALL return to IDLE.
REQ-027 Back-to-back: accept SHALL not occur in the same cycle as DONE->IDLE; minimum issue interval = L+1 cycles with out_ready held high.
REQ-028 flush=1 SHALL force IDLE on the next edge from any state, discarding any result; flush with in_valid in IDLE SHALL NOT accept.
REQ-029 An internal iteration counter SHALL terminate BUSY; no operation SHALL exceed WIDTH+1 cycles.

Reset
REQ-030 reset=1 SHALL immediately, without a clock edge, force IDLE, in_ready=1, out_valid=0, busy=0, out=0, and clear counter and datapath registers.
REQ-031 reset asserted mid-operation SHALL abort it; no result of that operation SHALL ever appear.
REQ-032 After reset release the first accept SHALL be possible on the first rising edge.

Verification
REQ-033 WIDTH=32, ADD 0xFFFFFFFF+1 -> out=0x00000000, out_valid after 1 edge; SLTU 1,0xFFFFFFFF -> 1; SLT same -> 0.
REQ-034 SRA 0x80000000 by 31 -> 0xFFFFFFFF after 31 edges; SLL 0x1 by 0 -> 0x1 after 1 edge.
REQ-035 MUL 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001, MULHU -> 0xFFFFFFFE, each after 32 edges.
REQ-036 DIV -7/2 -> 0xFFFFFFFD, REM -> 0xFFFFFFFF; DIVU 5/0 -> 0xFFFFFFFF, REMU -> 5; DIV 0x80000000/-1 -> 0x80000000; all after 33 edges.
REQ-037 DONE with out_ready=0 for 5 cycles -> out stable, in_ready=0; then out_ready=1 -> IDLE next edge.
REQ-038 reset pulse at cycle 10 of a DIVU, and separately flush at cycle 10 -> out_valid never rises, in_ready=1; next ADD 2+3 -> 5.
